// File: rtl/pe_mon_pkg.sv
// rtl/pe_mon_pkg.sv - shared state encoding and status register map for pe_result_monitor
package pe_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam logic [2:0] RA_STATUS   = 3'd0;
  localparam logic [2:0] RA_RES_CNT  = 3'd1;
  localparam logic [2:0] RA_CHECKSUM = 3'd2;
  localparam logic [2:0] RA_ERR1     = 3'd3;
  localparam logic [2:0] RA_ERR2     = 3'd4;
  localparam logic [2:0] RA_SEQ      = 3'd5;
  localparam logic [2:0] RA_FIRST    = 3'd6;
  localparam logic [2:0] RA_MAGIC    = 3'd7;

  localparam logic [15:0] MAGIC_WORD = 16'hA5C3;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating event counter with synchronous clear
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // clear has priority over a coincident increment; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pe_result_monitor.sv
// rtl/pe_result_monitor.sv - PE result run tracker with checksum, error statistics and status reads
module pe_result_monitor
  import pe_mon_pkg::*;
#(
  parameter int DATA_NUM   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run_start,
  input  logic                        res_vld,
  input  logic [$clog2(DATA_NUM)-1:0] res_addr,
  input  logic [DATA_WIDTH-1:0]       res_data,
  input  logic                        err1,
  input  logic                        err2,
  input  logic                        clr,
  input  logic                        rd_en,
  input  logic [2:0]                  rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_vld,
  output logic                        busy,
  output logic                        done,
  output logic                        fail
);

  localparam int AW = $clog2(DATA_NUM);
  localparam int RW = AW + 1;
  localparam logic [RW-1:0] LAST_IDX = RW'(DATA_NUM - 1);

  mon_state_e            state_q, state_d;
  logic [RW-1:0]         res_cnt;
  logic [RW-1:0]         first_err_idx;
  logic [DATA_WIDTH-1:0] checksum;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [CNT_WIDTH-1:0]  err1_cnt, err2_cnt, seq_err;
  logic                  fail_q, done_q, err1_q, err2_q;
  logic                  active, accept, stat_clr, rise1, rise2, seq_bad, last_res;

  // results only count while a run is open and not being restarted this cycle
  assign active   = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign accept   = active && res_vld && !run_start;
  assign stat_clr = run_start || clr;
  assign rise1    = active && err1 && !err1_q;
  assign rise2    = active && err2 && !err2_q;
  assign seq_bad  = accept && (res_addr != res_cnt[AW-1:0]);
  assign last_res = accept && (state_q == ST_RUN) && (res_cnt == LAST_IDX);

  // next-state: restart always wins, otherwise an accepted result advances the run
  always_comb begin
    state_d = state_q;
    if (run_start) begin
      state_d = ST_ARMED;
    end else if (accept) begin
      state_d = last_res ? ST_DONE : ST_RUN;
    end
  end

  // state register, done pulse and error-level history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err1_q  <= 1'b0;
      err2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_res && !run_start;
      err1_q  <= err1;
      err2_q  <= err2;
    end
  end

  // result count is run progress, so only a restart rewinds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (run_start) begin
      res_cnt <= '0;
    end else if (accept) begin
      res_cnt <= res_cnt + RW'(1);
    end
  end

  // running modular sum of accepted result words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (stat_clr) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + res_data;
    end
  end

  // first error event of the run captures the result index; fail stays set until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q        <= 1'b0;
      first_err_idx <= '1;
    end else if (stat_clr) begin
      fail_q        <= 1'b0;
      first_err_idx <= '1;
    end else if ((rise1 || rise2) && !fail_q) begin
      fail_q        <= 1'b1;
      first_err_idx <= res_cnt;
    end
  end

  sat_cnt #(.WIDTH(CNT_WIDTH)) u_err1_cnt (
    .clk(clk), .rst_n(rst_n), .inc(rise1), .clr(stat_clr), .q(err1_cnt)
  );

  sat_cnt #(.WIDTH(CNT_WIDTH)) u_err2_cnt (
    .clk(clk), .rst_n(rst_n), .inc(rise2), .clr(stat_clr), .q(err2_cnt)
  );

  sat_cnt #(.WIDTH(CNT_WIDTH)) u_seq_err (
    .clk(clk), .rst_n(rst_n), .inc(seq_bad), .clr(stat_clr), .q(seq_err)
  );

  // status register select, zero-extended to the read width
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      RA_STATUS:   rd_mux = DATA_WIDTH'({state_q, active, fail_q});
      RA_RES_CNT:  rd_mux = DATA_WIDTH'(res_cnt);
      RA_CHECKSUM: rd_mux = checksum;
      RA_ERR1:     rd_mux = DATA_WIDTH'(err1_cnt);
      RA_ERR2:     rd_mux = DATA_WIDTH'(err2_cnt);
      RA_SEQ:      rd_mux = DATA_WIDTH'(seq_err);
      RA_FIRST:    rd_mux = DATA_WIDTH'(first_err_idx);
      RA_MAGIC:    rd_mux = DATA_WIDTH'(MAGIC_WORD);
      default:     rd_mux = '0;
    endcase
  end

  // read port captures values as they stood before this cycle's updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

  assign busy = active;
  assign done = done_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_pe_result_monitor.sv
// tb/tb_pe_result_monitor.sv - scoreboard bench for pe_result_monitor against an event-level model
module tb_pe_result_monitor;

  localparam int DN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run_start = 1'b0;
  logic        res_vld = 1'b0;
  logic [3:0]  res_addr = '0;
  logic [15:0] res_data = '0;
  logic        err1 = 1'b0;
  logic        err2 = 1'b0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_vld;
  logic        busy;
  logic        done;
  logic        fail;

  int total = 0;
  int bad = 0;

  int    exp_q[$];
  string name_q[$];

  // model: run phase 0 idle, 1 armed, 2 run, 3 done
  int m_state, m_res, m_sum, m_e1, m_e2, m_seq, m_first;
  bit m_prev1, m_prev2, m_done;

  always #5 clk = ~clk;

  pe_result_monitor #(.DATA_NUM(DN), .DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .res_vld(res_vld),
    .res_addr(res_addr), .res_data(res_data), .err1(err1), .err2(err2),
    .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_vld(rd_vld), .busy(busy), .done(done), .fail(fail)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  function automatic int model_rd(input int a);
    int busy_m;
    busy_m = (m_state == 1 || m_state == 2) ? 1 : 0;
    case (a)
      0: return m_state * 4 + busy_m * 2 + ((m_first >= 0) ? 1 : 0);
      1: return m_res;
      2: return m_sum;
      3: return sat(m_e1);
      4: return sat(m_e2);
      5: return sat(m_seq);
      6: return (m_first < 0) ? 31 : m_first;
      default: return 16'hA5C3;
    endcase
  endfunction

  task automatic model_clear_stats();
    m_sum = 0; m_e1 = 0; m_e2 = 0; m_seq = 0; m_first = -1;
  endtask

  task automatic model_reset();
    m_state = 0; m_res = 0; m_prev1 = 0; m_prev2 = 0; m_done = 0;
    model_clear_stats();
  endtask

  // apply the currently driven inputs for one clock, update the model, check live outputs
  task automatic tick();
    bit act, r1, r2;
    act = (m_state == 1) || (m_state == 2);
    r1 = act && err1 && !m_prev1;
    r2 = act && err2 && !m_prev2;
    m_done = 0;
    if (rd_en) begin
      exp_q.push_back(model_rd(int'(rd_addr)));
      name_q.push_back($sformatf("rd_addr%0d", rd_addr));
    end
    if (run_start) begin
      m_state = 1;
      m_res = 0;
      model_clear_stats();
    end else begin
      if (clr) begin
        model_clear_stats();
      end else begin
        if (r1) m_e1++;
        if (r2) m_e2++;
        if ((r1 || r2) && m_first < 0) m_first = m_res;
      end
      if (act && res_vld) begin
        if (!clr) begin
          m_sum = (m_sum + int'(res_data)) % 65536;
          if (int'(res_addr) != m_res % DN) m_seq++;
        end
        m_res++;
        if (m_res == DN) begin
          m_state = 3;
          m_done = 1;
        end else begin
          m_state = 2;
        end
      end
    end
    m_prev1 = err1;
    m_prev2 = err2;
    @(posedge clk);
    #1;
    chk("done", int'(done), int'(m_done));
    chk("busy", int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
    chk("fail", int'(fail), (m_first >= 0) ? 1 : 0);
    run_start = 0; clr = 0; rd_en = 0; res_vld = 0;
  endtask

  task automatic read_reg(input int a);
    rd_en = 1;
    rd_addr = 3'(a);
    tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) read_reg(a);
  endtask

  task automatic result(input int a, input int d);
    res_vld = 1;
    res_addr = 4'(a);
    res_data = 16'(d);
    tick();
  endtask

  task automatic start_run();
    run_start = 1;
    tick();
  endtask

  // scoreboard monitor: every read response is matched against the oldest expectation
  always @(negedge clk) begin : mon
    int    e;
    string n;
    if (rst_n && rd_vld) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, int'(rd_data), e);
      end
    end
  end

  initial begin
    model_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_rd_vld", int'(rd_vld), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_fail", int'(fail), 0);
    rst_n = 1;
    read_all();

    // clean run: data 1..16 in order
    start_run();
    for (int i = 0; i < 16; i++) result(i, i + 1);
    read_all();
    result(0, 99);
    read_reg(1);

    // error flags: err1 with the 5th result, err2 later
    start_run();
    for (int i = 0; i < 16; i++) begin
      err1 = (i == 4);
      err2 = (i == 9);
      result(i, $urandom_range(0, 65535));
    end
    err1 = 0; err2 = 0;
    read_all();

    // wraparound sum and a skipped index
    start_run();
    result(0, 16'hFFFF);
    result(1, 16'hFFFF);
    read_reg(2);
    result(3, 5);
    read_reg(5);
    read_reg(1);

    // err1 toggled 300 times saturates its counter
    start_run();
    for (int i = 0; i < 300; i++) begin
      err1 = 1; tick();
      err1 = 0; tick();
    end
    read_reg(3);
    read_reg(6);

    // statistics clear keeps the run going
    clr = 1;
    tick();
    read_all();

    // restart during the 8th result, then reset mid-run
    start_run();
    for (int i = 0; i < 7; i++) result(i, i * 3);
    run_start = 1;
    result(7, 1234);
    read_reg(1);
    read_reg(0);
    for (int i = 0; i < 3; i++) result(i, 7);
    tick();
    rst_n = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_fail", int'(fail), 0);
    chk("midrst_rd_vld", int'(rd_vld), 0);
    chk("midrst_rd_data", int'(rd_data), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    read_all();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (m_state == 0 || m_state == 3) run_start = ($urandom_range(0, 3) == 0);
      else run_start = ($urandom_range(0, 79) == 0);
      clr = ($urandom_range(0, 59) == 0);
      res_vld = $urandom_range(0, 1) == 1;
      res_addr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(m_res % DN);
      res_data = 16'($urandom);
      err1 = ($urandom_range(0, 4) == 0);
      err2 = ($urandom_range(0, 4) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      rd_addr = 3'($urandom);
      tick();
    end
    err1 = 0; err2 = 0;
    read_all();
    tick();
    tick();
    chk("rd_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_result_monitor.md
PE_RESULT_MONITOR -- requirements
Module: pe_result_monitor

Interface
REQ-001 SHALL have parameter DATA_NUM, default 16, results per run (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, result word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, error counter width.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 run_start  input  1  one-cycle pulse, PE run begins.
REQ-007 res_vld  input  1  result-write strobe from PE output stage.
REQ-008 res_addr  input  $clog2(DATA_NUM)  result index.
REQ-009 res_data  input  DATA_WIDTH  result value.
REQ-010 err1  input  1  multiplier reverse-check flag, level.
REQ-011 err2  input  1  adder reverse-check flag, level.
REQ-012 clr  input  1  one-cycle pulse, clears statistics.
REQ-013 rd_en  input  1  status register read request.
REQ-014 rd_addr  input  3  status register index.
REQ-015 rd_data  output  DATA_WIDTH  read data, registered.
REQ-016 rd_vld  output  1  rd_data valid.
REQ-017 busy  output  1  high in ARMED or RUN.
REQ-018 done  output  1  one-cycle pulse on RUN->DONE.
REQ-019 fail  output  1  sticky: any err event since last clr/run_start.

Function
REQ-020 SHALL implement states IDLE, ARMED, RUN, DONE.
REQ-021 IDLE/DONE -> ARMED on run_start; clears res_cnt, checksum, first_err_idx, err counters, fail.
REQ-022 ARMED -> RUN on first res_vld; that result counted in the same cycle.
REQ-023 RUN -> DONE when res_cnt reaches DATA_NUM (last res_vld); done pulses the following cycle.
REQ-024 run_start while ARMED/RUN SHALL restart (-> ARMED, counters cleared); res_vld in same cycle ignored.
REQ-025 res_vld in IDLE/DONE SHALL be ignored.
REQ-026 each accepted res_vld: res_cnt += 1; checksum = (checksum + res_data) mod 2^DATA_WIDTH.
REQ-027 res_addr != res_cnt (low bits) SHALL increment seq_err counter (saturating).
REQ-028 err1/err2 rising edges (registered previous value) in ARMED/RUN SHALL each increment err1_cnt/err2_cnt, saturating at 2^CNT_WIDTH-1.
REQ-029 first error event of a run SHALL latch first_err_idx = res_cnt and set fail; later events do not modify first_err_idx.
REQ-030 simultaneous err1 and err2 edges SHALL increment both counters; first_err_idx latched once.
REQ-031 clr SHALL zero counters, checksum, fail, first_err_idx without changing state; clr and run_start together: run_start wins (superset).
REQ-032 read map: 0 {state,busy,fail}, 1 res_cnt, 2 checksum, 3 err1_cnt, 4 err2_cnt, 5 seq_err, 6 first_err_idx, 7 constant 16'hA5C3; zero-extended.
REQ-033 rd_vld/rd_data SHALL appear one cycle after rd_en; reads allowed in any state, return pre-update values of that cycle.
REQ-034 first_err_idx reads all-ones when no error latched.

Reset
REQ-035 rst_n low SHALL force IDLE; rd_data 0, rd_vld 0, busy 0, done 0, fail 0; counters, checksum 0; first_err_idx all-ones.
REQ-036 reset mid-RUN SHALL abort without done pulse.

Structure
REQ-037 state enum and read-address constants SHALL live in shared package pe_mon_pkg.
REQ-038 saturating counter SHALL be sub-module sat_cnt (params WIDTH; inc, clr, q), instantiated three times.

Verification
REQ-039 reset, run_start, 16 res_vld data 1..16 addr 0..15 -> done once, res_cnt 16, checksum 136, fail 0.
REQ-040 err1 pulse at 5th result -> err1_cnt 1, first_err_idx 4, fail 1; err2 pulse later -> err2_cnt 1, idx unchanged.
REQ-041 err1 held high 300 cycles with 300 edges toggled -> err1_cnt 255 (saturated).
REQ-042 data 16'hFFFF x2 -> checksum 16'hFFFE; addr skipped 3 -> seq_err 1.
REQ-043 run_start at 8th result -> res_cnt 0, busy 1, no done; rst_n low mid-RUN -> all reset values.
REQ-044 rd_en addr 7 -> rd_vld next cycle, rd_data 16'hA5C3.
